// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: opcode decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use stall, redirect flush and EX forwarding selects. Optional jal/jalr decode via PIPE_CTRL_JUMP_EN.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  ex_valid,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_illegal,
    output logic [1:0]            ex_alu_op,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_valid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_sel,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    logic       dec_alu_src, dec_branch, dec_illegal, dec_mem_read, dec_mem_write, dec_reg_write;
    logic       dec_use_rs1, dec_use_rs2;
    logic [1:0] dec_alu_op, dec_wb_sel;
`ifdef PIPE_CTRL_JUMP_EN
    logic       dec_jump, ex_jump_d, ex_jump_q;
`endif

    logic                  ex_valid_d, ex_alu_src_d, ex_branch_d, ex_illegal_d;
    logic                  ex_mem_read_d, ex_mem_write_d, ex_reg_write_d;
    logic [1:0]            ex_alu_op_d, ex_wb_sel_d;
    logic [REG_ADDR_W-1:0] ex_rs1_d, ex_rs2_d, ex_rd_d;
    logic                  ex_valid_q, ex_alu_src_q, ex_branch_q, ex_illegal_q;
    logic                  ex_mem_read_q, ex_mem_write_q, ex_reg_write_q;
    logic [1:0]            ex_alu_op_q, ex_wb_sel_q;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;

    logic                  mem_valid_d, mem_read_d, mem_write_d, mem_reg_write_d;
    logic [1:0]            mem_wb_sel_d;
    logic [REG_ADDR_W-1:0] mem_rd_d;
    logic                  mem_valid_q, mem_read_q, mem_write_q, mem_reg_write_q;
    logic [1:0]            mem_wb_sel_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;

    logic                  wb_valid_d, wb_reg_write_d;
    logic [1:0]            wb_sel_d;
    logic [REG_ADDR_W-1:0] wb_rd_d;
    logic                  wb_valid_q, wb_reg_write_q;
    logic [1:0]            wb_sel_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;

    logic bubble;

    always_comb begin
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        dec_illegal   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_use_rs1   = 1'b0;
        dec_use_rs2   = 1'b0;
        dec_alu_op    = 2'b00;
        dec_wb_sel    = 2'b00;
`ifdef PIPE_CTRL_JUMP_EN
        dec_jump      = 1'b0;
`endif
        case (id_opcode)
            7'b0110011: begin
                dec_reg_write = 1'b1; dec_alu_op = 2'b10;
                dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
            end
            7'b0010011: begin
                dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_op = 2'b11;
                dec_use_rs1 = 1'b1;
            end
            7'b0000011: begin
                dec_alu_src = 1'b1; dec_mem_read = 1'b1; dec_reg_write = 1'b1;
                dec_wb_sel = 2'b01; dec_use_rs1 = 1'b1;
            end
            7'b0100011: begin
                dec_alu_src = 1'b1; dec_mem_write = 1'b1;
                dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
            end
            7'b1100011: begin
                dec_branch = 1'b1; dec_alu_op = 2'b01;
                dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
            end
`ifdef PIPE_CTRL_JUMP_EN
            7'b1101111: begin
                dec_jump = 1'b1; dec_reg_write = 1'b1; dec_wb_sel = 2'b10;
            end
            7'b1100111: begin
                dec_jump = 1'b1; dec_reg_write = 1'b1; dec_alu_src = 1'b1;
                dec_wb_sel = 2'b10; dec_use_rs1 = 1'b1;
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

    // A redirect squashes the ID instruction anyway, so it overrides any load-use stall.
    always_comb begin
        stall_o = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != ZERO_REG) &&
                  ((dec_use_rs1 && (ex_rd_q == id_rs1)) || (dec_use_rs2 && (ex_rd_q == id_rs2))) &&
                  !ex_redirect;
        flush_o = ex_redirect;
        bubble  = !id_valid || stall_o || ex_redirect;
    end

    always_comb begin
        ex_valid_d     = !bubble;
        ex_alu_src_d   = bubble ? 1'b0 : dec_alu_src;
        ex_branch_d    = bubble ? 1'b0 : dec_branch;
        ex_illegal_d   = bubble ? 1'b0 : dec_illegal;
        ex_mem_read_d  = bubble ? 1'b0 : dec_mem_read;
        ex_mem_write_d = bubble ? 1'b0 : dec_mem_write;
        ex_reg_write_d = bubble ? 1'b0 : dec_reg_write;
        ex_alu_op_d    = bubble ? 2'b00 : dec_alu_op;
        ex_wb_sel_d    = bubble ? 2'b00 : dec_wb_sel;
        ex_rs1_d       = bubble ? ZERO_REG : id_rs1;
        ex_rs2_d       = bubble ? ZERO_REG : id_rs2;
        ex_rd_d        = bubble ? ZERO_REG : id_rd;
`ifdef PIPE_CTRL_JUMP_EN
        ex_jump_d      = bubble ? 1'b0 : dec_jump;
`endif
        mem_valid_d     = ex_valid_q;
        mem_read_d      = ex_mem_read_q;
        mem_write_d     = ex_mem_write_q;
        mem_reg_write_d = ex_reg_write_q;
        mem_wb_sel_d    = ex_wb_sel_q;
        mem_rd_d        = ex_rd_q;
        wb_valid_d      = mem_valid_q;
        wb_reg_write_d  = mem_reg_write_q;
        wb_sel_d        = mem_wb_sel_q;
        wb_rd_d         = mem_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0; ex_alu_src_q <= 1'b0; ex_branch_q <= 1'b0; ex_illegal_q <= 1'b0;
            ex_mem_read_q <= 1'b0; ex_mem_write_q <= 1'b0; ex_reg_write_q <= 1'b0;
            ex_alu_op_q <= 2'b00; ex_wb_sel_q <= 2'b00;
            ex_rs1_q <= ZERO_REG; ex_rs2_q <= ZERO_REG; ex_rd_q <= ZERO_REG;
`ifdef PIPE_CTRL_JUMP_EN
            ex_jump_q <= 1'b0;
`endif
            mem_valid_q <= 1'b0; mem_read_q <= 1'b0; mem_write_q <= 1'b0; mem_reg_write_q <= 1'b0;
            mem_wb_sel_q <= 2'b00; mem_rd_q <= ZERO_REG;
            wb_valid_q <= 1'b0; wb_reg_write_q <= 1'b0; wb_sel_q <= 2'b00; wb_rd_q <= ZERO_REG;
        end else begin
            ex_valid_q <= ex_valid_d; ex_alu_src_q <= ex_alu_src_d; ex_branch_q <= ex_branch_d;
            ex_illegal_q <= ex_illegal_d; ex_mem_read_q <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d; ex_reg_write_q <= ex_reg_write_d;
            ex_alu_op_q <= ex_alu_op_d; ex_wb_sel_q <= ex_wb_sel_d;
            ex_rs1_q <= ex_rs1_d; ex_rs2_q <= ex_rs2_d; ex_rd_q <= ex_rd_d;
`ifdef PIPE_CTRL_JUMP_EN
            ex_jump_q <= ex_jump_d;
`endif
            mem_valid_q <= mem_valid_d; mem_read_q <= mem_read_d; mem_write_q <= mem_write_d;
            mem_reg_write_q <= mem_reg_write_d; mem_wb_sel_q <= mem_wb_sel_d; mem_rd_q <= mem_rd_d;
            wb_valid_q <= wb_valid_d; wb_reg_write_q <= wb_reg_write_d;
            wb_sel_q <= wb_sel_d; wb_rd_q <= wb_rd_d;
        end
    end

    // EX/MEM takes precedence because it holds the younger result; bubbles and x0 never match.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid_q && mem_valid_q && mem_reg_write_q && (mem_rd_q != ZERO_REG) && (mem_rd_q == ex_rs1_q))
            fwd_a = 2'b10;
        else if (ex_valid_q && wb_valid_q && wb_reg_write_q && (wb_rd_q != ZERO_REG) && (wb_rd_q == ex_rs1_q))
            fwd_a = 2'b01;
        if (ex_valid_q && mem_valid_q && mem_reg_write_q && (mem_rd_q != ZERO_REG) && (mem_rd_q == ex_rs2_q))
            fwd_b = 2'b10;
        else if (ex_valid_q && wb_valid_q && wb_reg_write_q && (wb_rd_q != ZERO_REG) && (wb_rd_q == ex_rs2_q))
            fwd_b = 2'b01;
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_src   = ex_alu_src_q;
    assign ex_branch    = ex_branch_q;
    assign ex_illegal   = ex_illegal_q;
    assign ex_alu_op    = ex_alu_op_q;
`ifdef PIPE_CTRL_JUMP_EN
    assign ex_jump      = ex_jump_q;
`else
    assign ex_jump      = 1'b0;
`endif
    assign mem_valid    = mem_valid_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_sel       = wb_sel_q;
    assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit; jal expectations follow PIPE_CTRL_JUMP_EN.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b0001111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, ex_redirect;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_o, flush_o, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_illegal;
    logic [1:0] ex_alu_op, fwd_a, fwd_b, wb_sel;
    logic       mem_valid, mem_read, mem_write, wb_valid, wb_reg_write;
    logic [4:0] wb_rd;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl_unit #(.REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall_o(stall_o), .flush_o(flush_o), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_valid(mem_valid), .mem_read(mem_read),
        .mem_write(mem_write), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_sel(wb_sel), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [6:0] op,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ex_redirect = 1'b1;
        applyStimulus(1'b1, OP_LD, 5'd3, 5'd3, 5'd3);
        for (int i = 0; i < 3; i++) begin
            ex_redirect = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            tick();
        end
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_ex_alu_op", ex_alu_op, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_fwd_a", fwd_a, 0);
        checkOutput("rst_mem_valid", mem_valid, 0);
        checkOutput("rst_wb", {wb_valid, wb_reg_write, wb_sel, wb_rd}, 0);

        ex_redirect = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
        tick();
        checkOutput("r_ex_valid", ex_valid, 1);
        checkOutput("r_ex_alu_op", ex_alu_op, 2'b10);
        checkOutput("r_ex_alu_src", ex_alu_src, 0);
        applyStimulus(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        tick();
        checkOutput("r_mem_valid", mem_valid, 1);
        tick();
        checkOutput("r_wb", {wb_valid, wb_reg_write, wb_sel, wb_rd}, {1'b1, 1'b1, 2'b00, 5'd5});

        applyStimulus(1'b1, OP_LD, 5'd4, 5'd0, 5'd3);
        tick();
        checkOutput("ld_ex_alu_src", ex_alu_src, 1);
        applyStimulus(1'b1, OP_R, 5'd3, 5'd6, 5'd8);
        checkOutput("lu_stall_on", stall_o, 1);
        checkOutput("lu_flush", flush_o, 0);
        tick();
        checkOutput("lu_bubble", ex_valid, 0);
        checkOutput("lu_stall_off", stall_o, 0);
        checkOutput("lu_mem_read", mem_read, 1);
        tick();
        checkOutput("lu_add_ex", {ex_valid, ex_alu_op}, {1'b1, 2'b10});
        checkOutput("lu_fwd_a", fwd_a, 2'b01);
        checkOutput("lu_fwd_b", fwd_b, 2'b00);
        checkOutput("lu_wb_sel", {wb_sel, wb_rd}, {2'b01, 5'd3});

        applyStimulus(1'b1, OP_R, 5'd1, 5'd2, 5'd7);
        tick();
        applyStimulus(1'b1, OP_R, 5'd9, 5'd7, 5'd10);
        checkOutput("fx_no_stall", stall_o, 0);
        tick();
        checkOutput("fx_fwd_b", fwd_b, 2'b10);
        checkOutput("fx_fwd_a", fwd_a, 2'b00);
        applyStimulus(1'b1, OP_R, 5'd1, 5'd2, 5'd0);
        tick();
        applyStimulus(1'b1, OP_R, 5'd11, 5'd0, 5'd12);
        checkOutput("x0_no_stall", stall_o, 0);
        tick();
        checkOutput("x0_fwd_b", fwd_b, 2'b00);
        checkOutput("x0_fwd_a", fwd_a, 2'b00);

        applyStimulus(1'b1, OP_LD, 5'd1, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, OP_R, 5'd0, 5'd0, 5'd13);
        checkOutput("ld_x0_no_stall", stall_o, 0);

        applyStimulus(1'b1, OP_LD, 5'd1, 5'd0, 5'd3);
        tick();
        applyStimulus(1'b1, OP_ST, 5'd2, 5'd3, 5'd0);
        checkOutput("fl_pre_stall", stall_o, 1);
        ex_redirect = 1'b1;
        #1;
        checkOutput("fl_stall", stall_o, 0);
        checkOutput("fl_flush", flush_o, 1);
        tick();
        ex_redirect = 1'b0;
        checkOutput("fl_bubble", ex_valid, 0);

        applyStimulus(1'b1, OP_BAD, 5'd1, 5'd2, 5'd4);
        tick();
        checkOutput("ill_ex", {ex_valid, ex_illegal, ex_alu_op}, {1'b1, 1'b1, 2'b00});
        applyStimulus(1'b1, OP_ST, 5'd1, 5'd2, 5'd0);
        tick();
        checkOutput("ill_mem", {mem_valid, mem_write, mem_read}, {1'b1, 1'b0, 1'b0});
        checkOutput("st_ex", {ex_alu_src, ex_alu_op, ex_illegal}, {1'b1, 2'b00, 1'b0});
        applyStimulus(1'b1, OP_BR, 5'd1, 5'd2, 5'd0);
        tick();
        checkOutput("ill_wb", {wb_valid, wb_reg_write}, {1'b1, 1'b0});
        checkOutput("st_mem_write", mem_write, 1);
        checkOutput("br_ex", {ex_branch, ex_alu_op, ex_alu_src}, {1'b1, 2'b01, 1'b0});
        applyStimulus(1'b1, OP_I, 5'd1, 5'd0, 5'd6);
        tick();
        checkOutput("i_ex", {ex_alu_src, ex_alu_op, ex_branch}, {1'b1, 2'b11, 1'b0});

        applyStimulus(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1);
        tick();
`ifdef PIPE_CTRL_JUMP_EN
        checkOutput("jal_ex", {ex_jump, ex_illegal}, {1'b1, 1'b0});
`else
        checkOutput("jal_ex", {ex_jump, ex_illegal}, {1'b0, 1'b1});
`endif
        applyStimulus(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
`ifdef PIPE_CTRL_JUMP_EN
        checkOutput("jal_wb", {wb_reg_write, wb_sel, wb_rd}, {1'b1, 2'b10, 5'd1});
`else
        checkOutput("jal_wb", {wb_reg_write, wb_sel, wb_rd}, {1'b0, 2'b00, 5'd1});
`endif

        applyStimulus(1'b1, OP_R, 5'd1, 5'd2, 5'd9);
        tick();
        checkOutput("async_pre", ex_valid, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_ex_valid", ex_valid, 0);
        checkOutput("async_wb", {wb_valid, wb_sel, wb_rd}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage RISC-V core. It replaces the purely combinational opcode decoder with full 7-bit opcode decode and registers the control bundle through the ID/EX, EX/MEM and MEM/WB stages. It also detects load-use hazards, handles branch/jump flush with bubble insertion, and drives the operand-forwarding selects for the EX-stage ALU muxes.

## Interface
- `REG_ADDR_W`, default 5: register-index width.
- `clk` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: instruction present in ID.
- `id_opcode` in 7: instruction[6:0] in ID.
- `id_rs1`, `id_rs2`, `id_rd` in REG_ADDR_W: register fields in ID.
- `ex_redirect` in 1: branch taken or jump resolved in EX this cycle.
- `stall_o` out 1: freeze PC and IF/ID (combinational).
- `flush_o` out 1: squash IF/ID (combinational, equals `ex_redirect`).
- `ex_valid`, `ex_alu_src`, `ex_branch`, `ex_jump`, `ex_illegal` out 1: ID/EX bundle.
- `ex_alu_op` out 2: 00 add, 01 compare, 10 R-funct, 11 I-funct.
- `fwd_a`, `fwd_b` out 2: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- `mem_valid`, `mem_read`, `mem_write` out 1: EX/MEM bundle.
- `wb_valid`, `wb_reg_write` out 1; `wb_sel` out 2 (00 ALU, 01 mem, 10 PC+4); `wb_rd` out REG_ADDR_W: MEM/WB bundle.

## Operation
- Opcode decode on `id_opcode`:
  - 0110011 R-type: reg_write, alu_op=10.
  - 0010011 I-ALU: alu_src, reg_write, alu_op=11.
  - 0000011 load: alu_src, mem_read, reg_write, wb_sel=01, alu_op=00.
  - 0100011 store: alu_src, mem_write, alu_op=00.
  - 1100011 branch: branch, alu_op=01.
  - Any other opcode: all controls 0, illegal=1.
- Operand use:
  - rs1 is used by every legal opcode except jal.
  - rs2 is used only by R-type, store and branch.
- Load-use hazard: `stall_o` = `id_valid` & `ex_valid` & `ex_mem_read` & (EX rd≠0) & (EX rd matches a used ID rs).
- Stage advance:
  - Normal: ID/EX loads the decoded bundle, plus rs1/rs2/rd.
  - On stall or flush: ID/EX loads a bubble (valid=0, all controls 0, rd=0).
  - EX/MEM and MEM/WB always advance; they never stall.
- Flush priority: `ex_redirect` has priority. `stall_o` is forced to 0 while `flush_o`=1.
- Forwarding, per operand, from registered state:
  - 10 when MEM reg_write & mem_rd≠0 & mem_rd equals the EX rs.
  - Else 01 when `wb_reg_write` & `wb_rd`≠0 & `wb_rd` equals the EX rs.
  - Else 00.
  - Bubbles never forward.
- Register x0 never produces a hazard or a forward.

## Timing
- Latency: ID decode to `ex_*` is 1 cycle, to `mem_*` is 2 cycles, to `wb_*` is 3 cycles.
- `stall_o`, `flush_o`, `fwd_a` and `fwd_b` are combinational; there is no registered path from inputs to them.
- Reset: all registered outputs go to 0 (valid=0, wb_sel=00, rd=0) immediately on `rst_n` low, independent of `clk`.
  - Consequently `stall_o`=0 and `fwd_*`=00 during reset.
- Reset deasserted mid-stream: the first valid bundle appears in `ex_*` one clock after `id_valid` is sampled.
- Back-to-back stall: stays asserted as long as the condition holds. It cannot exceed 1 cycle for a single load, because the bubble clears `ex_mem_read`.
- `ex_redirect` and a hazard in the same cycle: bubble inserted, `stall_o`=0, `flush_o`=1.
- `id_valid`=0: decoded controls are ignored and ID/EX loads a bubble.

## Configuration
- Macro: `PIPE_CTRL_JUMP_EN`.
- Defined:
  - 1101111 jal decodes to jump, reg_write, wb_sel=10, with no rs use.
  - 1100111 jalr decodes to jump, reg_write, alu_src, wb_sel=10, alu_op=00, with rs1 used.
- Undefined:
  - Both opcodes decode as illegal.
  - `ex_jump` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0. Release, issue R-type rd=5 → `ex_alu_op`=10 after 1 clk, `wb_reg_write`=1 with `wb_rd`=5 after 3 clk.
- Load-use: load rd=3, then add rs1=3 → `stall_o`=1 for exactly 1 cycle, a bubble appears in EX, then `fwd_a`=01 when the add reaches EX.
- EX forwarding: add rd=7, then sub rs2=7 → `fwd_b`=10. Same sequence with rd=0 → `fwd_b`=00 and no stall.
- Flush priority: `ex_redirect`=1 while ID holds a load-use-dependent instruction → `stall_o`=0, `flush_o`=1, `ex_valid`=0 next cycle.
- Illegal opcode 0001111 → `ex_illegal`=1, `mem_write`=0, `wb_reg_write`=0.
- jal rd=1 → with `PIPE_CTRL_JUMP_EN`: `ex_jump`=1, `wb_sel`=10. Without it: `ex_illegal`=1, `ex_jump`=0.
